// File: rtl/mu0_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mu0_pkg
//  Purpose  : Shared MU0 datapath types and constants (word width, word type,
//             all-zero word used as the default register reset value).
//  Revision : 1.0 - initial release
// ============================================================================
package mu0_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t WORD_ZERO = '0;

endpackage : mu0_pkg
`default_nettype wire

// File: rtl/mu0_dff_en.sv
`default_nettype none
// ============================================================================
//  Module   : mu0_dff_en
//  Purpose  : Single-bit flop with synchronous active-high reset (priority)
//             and active-high load enable. Reset value comes from a port so
//             each bit of a wider register can take its own reset constant.
//  Ports    : clk_i      - clock, rising edge active
//             rst_i      - synchronous reset, active-high, beats en_i
//             en_i       - load enable
//             rst_val_i  - value taken on reset
//             d_i        - data to load
//             q_o        - flop output
//  Revision : 1.0 - initial release
// ============================================================================
module mu0_dff_en (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic rst_val_i,
    input  logic d_i,
    output logic q_o
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        if (en_i) begin
            q_d = d_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q <= rst_val_i;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule : mu0_dff_en
`default_nettype wire

// File: rtl/mu0_reg16.sv
`default_nettype none
// ============================================================================
//  Module   : mu0_reg16
//  Purpose  : Loadable data register for the MU0 datapath (ACC, PC, IR).
//             Captures D on the rising edge of Clk when En=1, holds otherwise.
//             Synchronous Reset loads RST_VAL and has priority over En.
//  Ports    : Clk   - system clock, rising edge active
//             Reset - synchronous reset, active-high
//             En    - load enable, active-high
//             D     - data to load [WIDTH-1:0]
//             Q     - register contents, straight from flops [WIDTH-1:0]
//  Options  : MU0_REG16_ASSERT_EN - when defined, adds simulation-only
//             protocol and behaviour checks; datapath is unchanged.
//  Revision : 1.0 - initial release
// ============================================================================
module mu0_reg16
    import mu0_pkg::*;
#(
    parameter int               WIDTH   = WORD_W,
    parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(WORD_ZERO)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    // One flop per bit; Q is wired directly to the flop outputs so there is
    // no combinational path from D to Q.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        mu0_dff_en u_dff (
            .clk_i     (Clk),
            .rst_i     (Reset),
            .en_i      (En),
            .rst_val_i (RST_VAL[i]),
            .d_i       (D[i]),
            .q_o       (Q[i])
        );
    end

`ifdef MU0_REG16_ASSERT_EN
    // Inputs and output seen at the previous edge. Q read at an edge is the
    // pre-update value, so chk_q_q holds the value Q had before that edge.
    logic [WIDTH-1:0] chk_q_q;
    logic             chk_rst_q;
    logic             chk_en_q;

    always_ff @(posedge Clk) begin
        chk_q_q   <= Q;
        chk_rst_q <= Reset;
        chk_en_q  <= En;
    end

    always @(posedge Clk) begin
        if ($isunknown(Reset)) begin
            $error("mu0_reg16: Reset is X/Z at time %0t", $time);
        end
        if ($isunknown(En)) begin
            $error("mu0_reg16: En is X/Z at time %0t", $time);
        end
        if ((En === 1'b1) && (Reset === 1'b0) && $isunknown(D)) begin
            $error("mu0_reg16: D is X/Z during load at time %0t", $time);
        end
        if ((chk_rst_q === 1'b0) && (chk_en_q === 1'b0) && (Q !== chk_q_q)) begin
            $error("mu0_reg16: Q changed while disabled at time %0t", $time);
        end
        if ((chk_rst_q === 1'b1) && (Q !== RST_VAL)) begin
            $error("mu0_reg16: Q not at reset value after reset at time %0t", $time);
        end
    end
`else
    // Checks excluded from this build.
`endif

endmodule : mu0_reg16
`default_nettype wire

// File: tb/tb_mu0_reg16.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_mu0_reg16
//  Purpose  : Directed self-checking bench for mu0_reg16. 100 ns clock with
//             rising edges at 50, 150, 250 ... ns; Q sampled 1 ns after edges
//             or mid-cycle where the timing of a change is under test.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mu0_reg16;

    logic        clk;
    logic        reset;
    logic        en;
    logic [15:0] d;
    logic [15:0] q;

    int checks   = 0;
    int failures = 0;

    mu0_reg16 dut (
        .Clk   (clk),
        .Reset (reset),
        .En    (en),
        .D     (d),
        .Q     (q)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] exp);
        checks++;
        assert (q === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h at %0t", tag, q, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: reset with load enabled; AAAA must never appear
        reset = 1'b1;
        en    = 1'b1;
        d     = 16'hAAAA;
        step();                         // edge 50
        check("rst_edge1", 16'h0000);
        step();                         // edge 150
        check("rst_edge2", 16'h0000);

        // 2: first enabled edge after reset loads D
        reset = 1'b0;
        d     = 16'hBBBB;
        step();                         // edge 250
        check("load_bbbb", 16'hBBBB);

        // 3: D changes with En=0 are ignored
        en = 1'b0;
        d  = 16'h1234;
        step();                         // edge 350
        check("hold1", 16'hBBBB);
        step();                         // edge 450
        check("hold2", 16'hBBBB);

        // Reset pulse entirely between edges (461..481) has no effect
        #10 reset = 1'b1;
        #20 reset = 1'b0;
        step();                         // edge 550
        check("pulse_between", 16'hBBBB);

        // 4: reset raised mid-cycle at 875 takes effect only at edge 950
        en = 1'b1;
        d  = 16'hBBBB;
        step();                         // edge 650
        step();                         // edge 750
        check("reload_bbbb", 16'hBBBB);
        #124;                           // 875
        reset = 1'b1;
        #25;                            // 900
        check("rst_midcycle", 16'hBBBB);
        step();                         // edge 950
        check("rst_at_950", 16'h0000);

        // 5: reset overrides the disabled state
        reset = 1'b0;
        en    = 1'b1;
        d     = 16'hCCCC;
        step();                         // edge 1050
        check("load_cccc", 16'hCCCC);
        reset = 1'b1;
        en    = 1'b0;
        d     = 16'h5555;
        step();                         // edge 1150
        check("rst_en0", 16'h0000);
        reset = 1'b0;
        step();                         // edge 1250
        check("hold_zero", 16'h0000);

        // 6: reset and enable together -> reset wins, then load on release
        en = 1'b1;
        d  = 16'h1357;
        step();                         // edge 1350
        check("load_1357", 16'h1357);
        reset = 1'b1;
        d     = 16'hFFFF;
        step();                         // edge 1450
        check("rst_beats_en", 16'h0000);
        reset = 1'b0;
        step();                         // edge 1550
        check("load_ffff", 16'hFFFF);

        // End bits in isolation
        d = 16'h8001;
        step();                         // edge 1650
        check("load_8001", 16'h8001);
        d = 16'h7FFE;
        step();                         // edge 1750
        check("load_7ffe", 16'h7FFE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mu0_reg16
`default_nettype wire

// File: doc/mu0_reg16.md
Name: mu0_reg16

Overview:
- 16-bit loadable data register for the MU0 datapath, used for ACC, PC and IR.
- Captures D on the rising clock edge when enabled and holds its value otherwise.
- Synchronous active-high Reset clears it to zero.

Parameters:
- WIDTH, 16, data width in bits. MU0 always uses 16; other values are for reuse only.
- RST_VAL, 16'h0000 (WIDTH bits), value loaded into Q on reset.

Ports:
- Clk  input  1  system clock. All state changes occur on the rising edge.
- Reset  input  1  reset, synchronous, active-high. It is sampled on the rising edge of Clk and has priority over En.
- En  input  1  load enable, active-high.
- D  input  WIDTH  data to load.
- Q  output  WIDTH  registered contents, driven directly from flops.
- Positional port order is fixed: Clk, Reset, En, D, Q.

Behaviour:
- One state register of WIDTH bits; Q always equals this register. There is no combinational path from D to Q.
- At each rising edge of Clk:
  - If Reset=1: Q <= RST_VAL. This holds regardless of En and D, including when En=0.
  - Else if En=1: Q <= D.
  - Else: Q holds its value.
- Reset is fully synchronous.
  - A Reset pulse that rises and falls between two rising edges has no effect.
  - When Reset is asserted mid-cycle, Q changes only at the next rising edge.
- Latency: Q reflects a load or reset one clock edge after the sampled inputs; new Q is visible immediately after the edge.
- If Reset and En are asserted in the same cycle, the reset wins and D is discarded.
- After Reset deasserts, the first edge with En=1 loads D.
- Power-up value before the first reset edge is unspecified (X in simulation). No initial blocks.
- D changing while En=0 never affects Q.
- The block is a single synchronous process. There are no latches and no asynchronous paths.

Optional Feature:
- Macro: MU0_REG16_ASSERT_EN.
- Defined: the block adds simulation-only checks, all evaluated at the rising edge of Clk:
  - Reset and En are never X/Z.
  - D is not X/Z when En=1 and Reset=0.
  - Q equals its previous value whenever Reset=0 and En=0.
  - Q equals RST_VAL one edge after Reset=1.
  - Each violation reports $error with the simulation time.
- Not defined: the check code is excluded entirely. RTL function and ports are identical in both cases.

Decomposition:
- Shared package mu0_pkg holds:
  - WORD_W = 16;
  - typedef word_t (logic [WORD_W-1:0]);
  - constant WORD_ZERO = '0.
- The register defaults to the package values.
- One natural sub-module: mu0_dff_en, a 1-bit flop with sync reset, enable and a reset-value input. It is instantiated WIDTH times via generate.
- A single always block is also acceptable.

Test Plan:
The clock period is 100 ns and rising edges fall at 50, 150, 250, … ns.
1. Reset=1, En=1, D=16'hAAAA over edges 50 and 150 -> Q=16'h0000 after the first edge; AAAA is never loaded.
2. Reset=0, En=1, D=16'hBBBB at edge 250 -> Q=16'hBBBB after that edge.
3. En=0, D changed to 16'h1234 for two edges -> Q stays 16'hBBBB.
4. With Q=16'hBBBB and En=1, assert Reset at 875 ns -> Q remains BBBB until edge 950 and becomes 0000 there. A Reset pulse entirely between edges leaves Q unchanged.
5. With Q=16'hCCCC and En=0, assert Reset across one edge -> Q=16'h0000 (reset overrides the disabled state).
6. Reset=1, En=1 and D=16'hFFFF in the same cycle -> Q=16'h0000. Deassert Reset with En=1 -> Q=16'hFFFF on the next edge.
